rob_commit_ctrl: RTL and testbench

- In-order retirement sequencer at the ROB head of the out-of-order core.
- Each cycle it inspects ROB entry 0. Completed ALU/load instructions retire with an R-RAT update and a ROB pop.
- Stores are drained to data memory over a req/ack handshake and retire only on ack.
- A mispredicted branch retires, then raises flush and redirect and blocks retirement for a drain window.

---
 rtl/core_pkg.sv | 38 +++
 rtl/rob_commit_ctrl_if.sv | 40 ++++
 rtl/store_align.sv | 49 ++++
 rtl/rob_commit_ctrl.sv | 131 +++++++++++++
 tb/tb_rob_commit_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// Shared commit-stage definitions: store/branch opcodes, dm_size encoding, commit FSM states.
package core_pkg;

  localparam logic [5:0] OP_SB     = 6'b101111;
  localparam logic [5:0] OP_SH     = 6'b110000;
  localparam logic [5:0] OP_SW     = 6'b110001;
  localparam logic [5:0] OP_SC     = 6'b110110;
  localparam logic [5:0] OP_SWL    = 6'b110010;
  localparam logic [5:0] OP_SWR    = 6'b110011;

  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;

  typedef enum logic [1:0] {
    DM_SIZE_WORD  = 2'd0,
    DM_SIZE_BYTE  = 2'd1,
    DM_SIZE_HALF  = 2'd2,
    DM_SIZE_THREE = 2'd3
  } dm_size_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_STORE = 2'd1,
    ST_DRAIN = 2'd2
  } commit_state_e;

  function automatic logic is_store(input logic [5:0] op);
    return op inside {OP_SB, OP_SH, OP_SW, OP_SC, OP_SWL, OP_SWR};
  endfunction

  function automatic logic is_branch(input logic [5:0] op);
    return op inside {OP_REGIMM, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ};
  endfunction

endpackage

// File: rtl/rob_commit_ctrl_if.sv
// ROB-head and data-memory signals of the commit stage; slave is the commit controller side.
interface rob_commit_ctrl_if;
  logic        head_valid;
  logic        head_done;
  logic [31:0] head_instr;
  logic [5:0]  head_phy_write;
  logic [4:0]  head_arch_write;
  logic [31:0] head_addr;
  logic [31:0] head_store_data;
  logic        head_mispredict;
  logic [31:0] head_target;
  logic        dm_ack;

  logic        rob_pop;
  logic        rrat_we;
  logic [4:0]  rrat_arch;
  logic [5:0]  rrat_phy;
  logic        dm_req;
  logic [31:0] dm_addr;
  logic [31:0] dm_data;
  logic [1:0]  dm_size;
  logic        flush;
  logic [31:0] redirect_pc;
  logic [31:0] retire_count;
  logic        err_timeout;

  modport master (
    output head_valid, head_done, head_instr, head_phy_write, head_arch_write,
           head_addr, head_store_data, head_mispredict, head_target, dm_ack,
    input  rob_pop, rrat_we, rrat_arch, rrat_phy, dm_req, dm_addr, dm_data,
           dm_size, flush, redirect_pc, retire_count, err_timeout
  );

  modport slave (
    input  head_valid, head_done, head_instr, head_phy_write, head_arch_write,
           head_addr, head_store_data, head_mispredict, head_target, dm_ack,
    output rob_pop, rrat_we, rrat_arch, rrat_phy, dm_req, dm_addr, dm_data,
           dm_size, flush, redirect_pc, retire_count, err_timeout
  );
endinterface

// File: rtl/store_align.sv
// Combinational store formatter: opcode + address low bits + register data -> memory write fields.
module store_align
  import core_pkg::*;
(
  input  logic [5:0]  opcode,
  input  logic [31:0] addr,
  input  logic [31:0] data,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_data,
  output logic [1:0]  dm_size
);

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    dm_addr = addr;
    dm_data = data;
    dm_size = DM_SIZE_WORD;
    case (opcode)
      OP_SB: begin
        dm_data = {24'b0, data[7:0]};
        dm_size = DM_SIZE_BYTE;
      end
      OP_SH: begin
        dm_data = {16'b0, data[15:0]};
        dm_size = DM_SIZE_HALF;
      end
      OP_SWL: begin
        case (addr[1:0])
          2'd1:    begin dm_data = {8'b0,  data[31:8]};  dm_size = DM_SIZE_THREE; end
          2'd2:    begin dm_data = {16'b0, data[31:16]}; dm_size = DM_SIZE_HALF;  end
          2'd3:    begin dm_data = {24'b0, data[31:24]}; dm_size = DM_SIZE_BYTE;  end
          default: ;
        endcase
      end
      OP_SWR: begin
        // SWR writes the low bytes of the register starting at the aligned word.
        dm_addr = {addr[31:2], 2'b00};
        case (addr[1:0])
          2'd0:    begin dm_data = {24'b0, data[7:0]};  dm_size = DM_SIZE_BYTE;  end
          2'd1:    begin dm_data = {16'b0, data[15:0]}; dm_size = DM_SIZE_HALF;  end
          2'd2:    begin dm_data = {8'b0,  data[23:0]}; dm_size = DM_SIZE_THREE; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/rob_commit_ctrl.sv
// In-order ROB-head retirement: R-RAT update, store drain over req/ack, mispredict flush + drain window.
// Optional macro COMMIT_PERF_EN adds retire_count and the sticky err_timeout store-ack watchdog.
module rob_commit_ctrl
  import core_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int DM_TIMEOUT   = 64
) (
  input  logic             CLK,
  input  logic             RESET,
  rob_commit_ctrl_if.slave bus
);

  commit_state_e state;
  logic [3:0]    drain_cnt;
  logic          req_q;
  logic [31:0]   addr_q;
  logic [31:0]   data_q;
  logic [1:0]    size_q;

  logic [5:0]  opcode;
  logic [31:0] al_addr;
  logic [31:0] al_data;
  logic [1:0]  al_size;
  logic        head_ret;
  logic        retire_now;
  logic        store_start;
  logic        take_flush;

  assign opcode = bus.head_instr[31:26];

  store_align u_store_align (
    .opcode  (opcode),
    .addr    (bus.head_addr),
    .data    (bus.head_store_data),
    .dm_addr (al_addr),
    .dm_data (al_data),
    .dm_size (al_size)
  );

  assign head_ret    = (state == ST_IDLE) && bus.head_valid && bus.head_done;
  assign retire_now  = head_ret && !is_store(opcode);
  assign store_start = head_ret && is_store(opcode);
  assign take_flush  = retire_now && is_branch(opcode) && bus.head_mispredict;

  // Retirement side effects are combinational so the ROB shifts in the same cycle.
  assign bus.rob_pop     = retire_now || ((state == ST_STORE) && bus.dm_ack);
  assign bus.rrat_we     = retire_now && (bus.head_arch_write != 5'd0);
  assign bus.rrat_arch   = bus.rrat_we ? bus.head_arch_write : 5'd0;
  assign bus.rrat_phy    = bus.rrat_we ? bus.head_phy_write : 6'd0;
  assign bus.flush       = take_flush;
  assign bus.redirect_pc = take_flush ? bus.head_target : 32'd0;

  assign bus.dm_req  = req_q;
  assign bus.dm_addr = addr_q;
  assign bus.dm_data = data_q;
  assign bus.dm_size = size_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state     <= ST_IDLE;
      drain_cnt <= 4'd0;
      req_q     <= 1'b0;
      addr_q    <= 32'd0;
      data_q    <= 32'd0;
      size_q    <= 2'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (store_start) begin
            req_q  <= 1'b1;
            addr_q <= al_addr;
            data_q <= al_data;
            size_q <= al_size;
            state  <= ST_STORE;
          end else if (take_flush) begin
            drain_cnt <= 4'(FLUSH_CYCLES);
            state     <= ST_DRAIN;
          end
        end
        ST_STORE: begin
          if (bus.dm_ack) begin
            req_q <= 1'b0;
            state <= ST_IDLE;
          end
        end
        ST_DRAIN: begin
          drain_cnt <= drain_cnt - 4'd1;
          if (drain_cnt <= 4'd1) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef COMMIT_PERF_EN
  localparam int TW = $clog2(DM_TIMEOUT + 1);

  logic [31:0]   retire_cnt_q;
  logic [TW-1:0] wait_cnt;
  logic          err_q;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      retire_cnt_q <= 32'd0;
      wait_cnt     <= '0;
      err_q        <= 1'b0;
    end else begin
      if (bus.rob_pop) retire_cnt_q <= retire_cnt_q + 32'd1;
      // Saturating wait counter; the store itself keeps waiting after the flag is raised.
      if (req_q && !bus.dm_ack) begin
        if (wait_cnt == TW'(DM_TIMEOUT - 1)) err_q <= 1'b1;
        if (wait_cnt != TW'(DM_TIMEOUT)) wait_cnt <= wait_cnt + 1'b1;
      end else begin
        wait_cnt <= '0;
      end
    end
  end

  assign bus.retire_count = retire_cnt_q;
  assign bus.err_timeout  = err_q;
`else
  assign bus.retire_count = 32'd0;
  assign bus.err_timeout  = 1'b0;
`endif

  logic unused_bits;
  assign unused_bits = ^{bus.head_instr[25:0], DM_TIMEOUT[0]};

endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Directed bench for rob_commit_ctrl: a per-cycle reference model plus literal spot checks.
module tb_rob_commit_ctrl;

  localparam int FLUSH = 2;
  localparam int TMO   = 64;

  localparam logic [5:0] ADD = 6'b000000, SB = 6'b101111, SH = 6'b110000, SW = 6'b110001;
  localparam logic [5:0] SC  = 6'b110110, SWL = 6'b110010, SWR = 6'b110011;
  localparam logic [5:0] BRZ = 6'b000001, BEQ = 6'b000100, BNE = 6'b000101;

  logic CLK = 1'b0;
  logic RESET = 1'b0;
  always #5 CLK = ~CLK;

  rob_commit_ctrl_if bus ();

  rob_commit_ctrl #(.FLUSH_CYCLES(FLUSH), .DM_TIMEOUT(TMO)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending store, remaining drain cycles, perf counters.
  bit          m_pend  = 0;
  logic [31:0] m_addr  = 0;
  logic [31:0] m_data  = 0;
  logic [1:0]  m_size  = 0;
  int          m_drain = 0;
  logic [31:0] m_rcount = 0;
  int          m_wait  = 0;
  bit          m_err   = 0;

  function automatic bit op_is_store(input logic [5:0] op);
    return op inside {6'b101111, 6'b110000, 6'b110001, 6'b110110, 6'b110010, 6'b110011};
  endfunction

  function automatic bit op_is_branch(input logic [5:0] op);
    return op inside {6'b000001, 6'b000100, 6'b000101, 6'b000110, 6'b000111};
  endfunction

  // Byte-count view of store formatting: pick nbytes starting at byte 'shift', size = nbytes mod 4.
  function automatic void align(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d,
                                output logic [31:0] oa, output logic [31:0] od, output logic [1:0] os);
    int k, nbytes, shift;
    logic [63:0] mask;
    k = int'(a[1:0]);
    oa = a;
    shift = 0;
    nbytes = 4;
    if (op == SB) nbytes = 1;
    else if (op == SH) nbytes = 2;
    else if (op == SWL) begin nbytes = 4 - k; shift = 8 * k; end
    else if (op == SWR) begin nbytes = k + 1; oa = a & 32'hFFFF_FFFC; end
    mask = (64'd1 << (8 * nbytes)) - 64'd1;
    od = 32'((64'(d) >> shift) & mask);
    os = 2'(nbytes % 4);
  endfunction

  function automatic void expect_comb(output bit pop, output bit we, output bit fl,
                                      output logic [4:0] ar, output logic [5:0] ph,
                                      output logic [31:0] pc);
    bit idle, ret, st;
    logic [5:0] op;
    op   = bus.head_instr[31:26];
    st   = op_is_store(op);
    idle = !m_pend && (m_drain == 0);
    ret  = idle && bus.head_valid && bus.head_done;
    pop  = (ret && !st) || (m_pend && bus.dm_ack);
    we   = ret && !st && (bus.head_arch_write != 0);
    fl   = ret && !st && op_is_branch(op) && bus.head_mispredict;
    ar   = we ? bus.head_arch_write : 5'd0;
    ph   = we ? bus.head_phy_write : 6'd0;
    pc   = fl ? bus.head_target : 32'd0;
  endfunction

  always @(negedge RESET) begin
    m_pend = 0; m_addr = 0; m_data = 0; m_size = 0;
    m_drain = 0; m_rcount = 0; m_wait = 0; m_err = 0;
  end

  always @(posedge CLK) begin
    bit pop, we, fl;
    logic [4:0] ar;
    logic [5:0] ph;
    logic [31:0] pc;
    if (RESET) begin
      expect_comb(pop, we, fl, ar, ph, pc);
      if (pop) m_rcount = m_rcount + 1;
      if (m_pend && !bus.dm_ack) begin
        m_wait++;
        if (m_wait >= TMO) m_err = 1;
      end else m_wait = 0;
      if (m_drain > 0) m_drain--;
      else if (m_pend) begin
        if (bus.dm_ack) m_pend = 0;
      end else if (bus.head_valid && bus.head_done && op_is_store(bus.head_instr[31:26])) begin
        align(bus.head_instr[31:26], bus.head_addr, bus.head_store_data, m_addr, m_data, m_size);
        m_pend = 1;
      end else if (fl) m_drain = FLUSH;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge CLK) begin
    bit pop, we, fl;
    logic [4:0] ar;
    logic [5:0] ph;
    logic [31:0] pc;
    expect_comb(pop, we, fl, ar, ph, pc);
    check("rob_pop",     32'(bus.rob_pop),   32'(pop));
    check("rrat_we",     32'(bus.rrat_we),   32'(we));
    check("rrat_arch",   32'(bus.rrat_arch), 32'(ar));
    check("rrat_phy",    32'(bus.rrat_phy),  32'(ph));
    check("flush",       32'(bus.flush),     32'(fl));
    check("redirect_pc", bus.redirect_pc,    pc);
    check("dm_req",      32'(bus.dm_req),    32'(m_pend));
    check("dm_addr",     bus.dm_addr,        m_addr);
    check("dm_data",     bus.dm_data,        m_data);
    check("dm_size",     32'(bus.dm_size),   32'(m_size));
`ifdef COMMIT_PERF_EN
    check("retire_count", bus.retire_count,      m_rcount);
    check("err_timeout",  32'(bus.err_timeout),  32'(m_err));
`else
    check("retire_count", bus.retire_count,      32'd0);
    check("err_timeout",  32'(bus.err_timeout),  32'd0);
`endif
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic at_neg();
    @(negedge CLK);
  endtask

  task automatic head(input logic [5:0] op, input logic [4:0] arch, input logic [5:0] phy,
                      input logic [31:0] addr, input logic [31:0] data,
                      input logic misp, input logic [31:0] tgt);
    bus.head_valid      = 1'b1;
    bus.head_done       = 1'b1;
    bus.head_instr      = {op, 26'h0155AA5};
    bus.head_arch_write = arch;
    bus.head_phy_write  = phy;
    bus.head_addr       = addr;
    bus.head_store_data = data;
    bus.head_mispredict = misp;
    bus.head_target     = tgt;
  endtask

  logic [5:0] store_ops [6] = '{SH, SW, SC, SWL, SWR, SB};

  initial begin
    bus.head_valid = 0; bus.head_done = 0; bus.head_instr = 0; bus.head_phy_write = 0;
    bus.head_arch_write = 0; bus.head_addr = 0; bus.head_store_data = 0;
    bus.head_mispredict = 0; bus.head_target = 0; bus.dm_ack = 0;
    tick(); tick();
    at_neg();
    check("reset_pop", 32'(bus.rob_pop), 32'd0);
    check("reset_req", 32'(bus.dm_req), 32'd0);
    check("reset_flush", 32'(bus.flush), 32'd0);
    tick();
    RESET = 1'b1;
    tick();

    // ADD with an architectural destination
    head(ADD, 5'd5, 6'd40, 0, 0, 0, 0);
    at_neg();
    check("add_pop", 32'(bus.rob_pop), 32'd1);
    check("add_we", 32'(bus.rrat_we), 32'd1);
    check("add_arch", 32'(bus.rrat_arch), 32'd5);
    check("add_phy", 32'(bus.rrat_phy), 32'd40);
    tick();
    head(ADD, 5'd0, 6'd7, 0, 0, 0, 0);
    at_neg();
    check("r0_pop", 32'(bus.rob_pop), 32'd1);
    check("r0_we", 32'(bus.rrat_we), 32'd0);
    tick();

    // SB with ack withheld for three cycles
    head(SB, 5'd0, 6'd0, 32'h1003, 32'hAABBCCDD, 0, 0);
    at_neg();
    check("sb_issue_pop", 32'(bus.rob_pop), 32'd0);
    tick();
    at_neg();
    check("sb_req", 32'(bus.dm_req), 32'd1);
    check("sb_size", 32'(bus.dm_size), 32'd1);
    check("sb_data", bus.dm_data, 32'h0000_00DD);
    check("sb_addr", bus.dm_addr, 32'h0000_1003);
    tick(); tick();
    at_neg();
    check("sb_wait_pop", 32'(bus.rob_pop), 32'd0);
    check("sb_wait_data", bus.dm_data, 32'h0000_00DD);
    tick();
    bus.dm_ack = 1'b1;
    at_neg();
    check("sb_ack_pop", 32'(bus.rob_pop), 32'd1);
    check("sb_ack_we", 32'(bus.rrat_we), 32'd0);
    tick();
    bus.dm_ack = 1'b0;
    bus.head_valid = 1'b0;
    at_neg();
    check("sb_req_drop", 32'(bus.dm_req), 32'd0);
    tick();
    bus.dm_ack = 1'b1;
    at_neg();
    check("stray_ack_pop", 32'(bus.rob_pop), 32'd0);
    tick();
    bus.dm_ack = 1'b0;

    // SWR at a half-word offset, acked in its first request cycle
    head(SWR, 5'd0, 6'd0, 32'h2002, 32'h11223344, 0, 0);
    tick();
    bus.dm_ack = 1'b1;
    at_neg();
    check("swr_addr", bus.dm_addr, 32'h0000_2000);
    check("swr_data", bus.dm_data, 32'h0022_3344);
    check("swr_size", 32'(bus.dm_size), 32'd3);
    check("swr_pop", 32'(bus.rob_pop), 32'd1);
    tick();
    bus.dm_ack = 1'b0;

    // Every store opcode at every byte offset
    foreach (store_ops[i]) begin
      for (int k = 0; k < 4; k++) begin
        head(store_ops[i], 5'd0, 6'd0, 32'h3000 + k, 32'h8765_4321, 0, 0);
        tick();
        bus.dm_ack = 1'b1;
        tick();
        bus.dm_ack = 1'b0;
      end
    end
    bus.head_valid = 1'b0;
    tick();

    // BNE mispredict followed by a done ADD held off by the drain window
    head(BNE, 5'd0, 6'd0, 0, 0, 1'b1, 32'h0040_0100);
    at_neg();
    check("bne_flush", 32'(bus.flush), 32'd1);
    check("bne_pc", bus.redirect_pc, 32'h0040_0100);
    check("bne_pop", 32'(bus.rob_pop), 32'd1);
    tick();
    head(ADD, 5'd3, 6'd9, 0, 0, 0, 0);
    at_neg();
    check("drain1_pop", 32'(bus.rob_pop), 32'd0);
    check("drain1_flush", 32'(bus.flush), 32'd0);
    tick();
    at_neg();
    check("drain2_pop", 32'(bus.rob_pop), 32'd0);
    tick();
    at_neg();
    check("after_drain_pop", 32'(bus.rob_pop), 32'd1);
    check("after_drain_we", 32'(bus.rrat_we), 32'd1);
    tick();

    // Mispredict flag on a non-branch, correct branch, mispredicted branch with R-RAT write
    head(ADD, 5'd4, 6'd11, 0, 0, 1'b1, 32'hDEAD_0000);
    at_neg();
    check("alu_misp_flush", 32'(bus.flush), 32'd0);
    tick();
    head(BEQ, 5'd31, 6'd63, 0, 0, 1'b0, 32'h1234);
    tick();
    head(BRZ, 5'd6, 6'd20, 0, 0, 1'b1, 32'h8000);
    tick();
    bus.head_valid = 1'b0;
    tick(); tick(); tick();

    // Asynchronous reset while a store is outstanding
    head(SW, 5'd0, 6'd0, 32'h44, 32'h5555, 0, 0);
    tick();
    at_neg();
    check("rst_pre_req", 32'(bus.dm_req), 32'd1);
    @(posedge CLK);
    #2;
    RESET = 1'b0;
    bus.head_valid = 1'b0;
    #1;
    check("rst_async_req", 32'(bus.dm_req), 32'd0);
    tick(); tick();
    RESET = 1'b1;
    tick();

`ifdef COMMIT_PERF_EN
    head(SW, 5'd0, 6'd0, 32'h80, 32'h1234, 0, 0);
    tick();
    repeat (TMO - 1) tick();
    at_neg();
    check("tmo_before", 32'(bus.err_timeout), 32'd0);
    tick();
    at_neg();
    check("tmo_after", 32'(bus.err_timeout), 32'd1);
    tick();
    bus.dm_ack = 1'b1;
    tick();
    bus.dm_ack = 1'b0;
    bus.head_valid = 1'b0;
    tick(); tick();
`endif

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
